// File: rtl/out_sel_pipe_pkg.sv
// Shared router definitions used by the output-select pipeline:
// default port geometry and the select code that marks an idle input.
package out_sel_pipe_pkg;

  localparam int DEF_NUM_CHANNEL  = 5;
  localparam int DEF_LOG_NUM_PORT = 3;

  // Idle code is the all-ones value of a select code of the given width.
  function automatic logic [31:0] idle_code(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/out_sel_enc.sv
// Translates one allocation vector into a select code.
// An all-zero vector produces the idle code.
// A vector with more than one bit set is flagged; the priority setting still picks the winner.
module out_sel_enc
  import out_sel_pipe_pkg::*;
#(
  parameter int NUM_CHANNEL  = DEF_NUM_CHANNEL,
  parameter int LOG_NUM_PORT = DEF_LOG_NUM_PORT,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic [NUM_CHANNEL-1:0]  vec,
  output logic [LOG_NUM_PORT-1:0] code,
  output logic                    multi
);

  localparam logic [LOG_NUM_PORT-1:0] IDLE = LOG_NUM_PORT'(idle_code(LOG_NUM_PORT));

  int ones;

  // Priority encode with a running popcount. With MSB priority every later set bit
  // overwrites the code. With LSB priority only the first set bit is kept: the idle code
  // is larger than any channel index, so it marks "no winner yet".
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    code  = IDLE;
    ones  = 0;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      if (vec[i]) begin
        ones = ones + 1;
        if (MSB_FIRST || code == IDLE) code = LOG_NUM_PORT'(i);
      end
    end
    multi = (ones > 1);
  end

endmodule

// File: rtl/out_sel_pipe.sv
// Single-stage registered translation of per-input allocation vectors into crossbar
// select codes. The stage provides valid/ready handshaking at full throughput.
// It also detects conflicts between inputs, keeps sticky multi-hot error flags,
// and maintains a saturating conflict counter.
module out_sel_pipe
  import out_sel_pipe_pkg::*;
#(
  parameter int NUM_CHANNEL  = DEF_NUM_CHANNEL,
  parameter int NUM_IN       = 5,
  parameter int LOG_NUM_PORT = DEF_LOG_NUM_PORT,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_IN*NUM_CHANNEL-1:0]  alloc,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_IN*LOG_NUM_PORT-1:0] out_sel,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           err_clr,
  output logic [NUM_IN-1:0]              err_multi,
  output logic                           conflict,
  output logic [CNT_W-1:0]               conflict_cnt
);

  localparam logic [LOG_NUM_PORT-1:0] IDLE = LOG_NUM_PORT'(idle_code(LOG_NUM_PORT));

  if ((1 << LOG_NUM_PORT) <= NUM_CHANNEL) begin : g_bad_width
    $error("out_sel_pipe: LOG_NUM_PORT too small to hold an idle code beyond NUM_CHANNEL");
  end

  logic [LOG_NUM_PORT-1:0]        code [NUM_IN];
  logic [NUM_IN-1:0]              multi;
  logic [NUM_IN*LOG_NUM_PORT-1:0] sel_next;
  logic                           conflict_next;
  logic                           in_xfer;
  logic                           out_xfer;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_enc
    out_sel_enc #(
      .NUM_CHANNEL (NUM_CHANNEL),
      .LOG_NUM_PORT(LOG_NUM_PORT),
      .MSB_FIRST   (MSB_FIRST)
    ) u_enc (
      .vec  (alloc[g*NUM_CHANNEL +: NUM_CHANNEL]),
      .code (code[g]),
      .multi(multi[g])
    );
    assign sel_next[g*LOG_NUM_PORT +: LOG_NUM_PORT] = code[g];
  end

  // The stage can take a new vector whenever the held result is absent or leaving.
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Two active inputs selecting the same channel form a conflict. Idle inputs never conflict.
  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = i + 1; j < NUM_IN; j++) begin
        if (code[i] != IDLE && code[i] == code[j]) conflict_next = 1'b1;
      end
    end
  end

  // Result register: loads on input transfer and empties on a bare output transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_valid <= 1'b0;
      out_sel   <= {NUM_IN{IDLE}};
      conflict  <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_sel   <= sel_next;
      conflict  <= conflict_next;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky multi-hot flags: a new multi-hot input sets its flag even while clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_multi <= '0;
    end else begin
      err_multi <= (err_clr ? '0 : err_multi) | (in_xfer ? multi : '0);
    end
  end

  // Saturating count of accepted results that carry a conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (in_xfer && conflict_next && conflict_cnt != {CNT_W{1'b1}}) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_out_sel_pipe.sv
// Directed bench for out_sel_pipe. One instance uses the defaults (MSB priority, 8-bit counter).
// A second instance uses LSB priority and a 2-bit counter. Both instances share the same stimulus.
module tb_out_sel_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] alloc;
  logic        in_valid;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready_a, out_valid_a, conflict_a;
  logic [14:0] out_sel_a;
  logic [4:0]  err_multi_a;
  logic [7:0]  cnt_a;

  logic        in_ready_b, out_valid_b, conflict_b;
  logic [14:0] out_sel_b;
  logic [4:0]  err_multi_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  out_sel_pipe dut_a (
    .clk(clk), .reset(reset), .alloc(alloc), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_sel(out_sel_a), .out_valid(out_valid_a), .out_ready(out_ready), .err_clr(err_clr),
    .err_multi(err_multi_a), .conflict(conflict_a), .conflict_cnt(cnt_a)
  );

  out_sel_pipe #(.MSB_FIRST(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .alloc(alloc), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_sel(out_sel_b), .out_valid(out_valid_b), .out_ready(out_ready), .err_clr(err_clr),
    .err_multi(err_multi_b), .conflict(conflict_b), .conflict_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] vecs(input logic [4:0] v0, v1, v2, v3, v4);
    return {v4, v3, v2, v1, v0};
  endfunction

  function automatic logic [14:0] sels(input logic [2:0] s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  localparam logic [14:0] ALL_IDLE = 15'h7FFF;

  logic [14:0] held;

  initial begin
    reset = 1'b1; alloc = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    cycle(); cycle();
    reset = 1'b0; #1;

    // Reset state
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready",  in_ready_a, 1);
    check("rst_out_sel",   out_sel_a, ALL_IDLE);
    check("rst_conflict",  conflict_a, 0);
    check("rst_err_multi", err_multi_a, 0);
    check("rst_cnt",       cnt_a, 0);

    // Multi-hot on input 0: MSB wins (4), LSB wins (2); idle slices give 7
    alloc = vecs(5'b10100, 0, 0, 0, 0); in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; alloc = '0;
    check("msb_sel",         out_sel_a, sels(4, 7, 7, 7, 7));
    check("msb_out_valid",   out_valid_a, 1);
    check("msb_err_multi",   err_multi_a, 5'b00001);
    check("lsb_sel",         out_sel_b, sels(2, 7, 7, 7, 7));
    check("lsb_err_multi",   err_multi_b, 5'b00001);
    check("msb_no_conflict", conflict_a, 0);

    // Bare output transfer empties the stage and holds the data
    cycle();
    check("drain_out_valid", out_valid_a, 0);
    check("drain_sel_hold",  out_sel_a, sels(4, 7, 7, 7, 7));

    // Clear sticky flags
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("clr_err_multi", err_multi_a, 0);

    // Inputs 1 and 3 select the same channel
    alloc = vecs(0, 5'b00010, 0, 5'b00010, 0); in_valid = 1'b1;
    cycle();
    check("conf_sel",      out_sel_a, sels(7, 1, 7, 1, 7));
    check("conf_flag",     conflict_a, 1);
    check("conf_cnt",      cnt_a, 1);
    check("conf_cnt_b",    cnt_b, 1);
    check("conf_no_multi", err_multi_a, 0);

    // All idle vectors: no conflict, counter holds
    alloc = '0;
    cycle();
    check("idle_sel",      out_sel_a, ALL_IDLE);
    check("idle_conflict", conflict_a, 0);
    check("idle_cnt",      cnt_a, 1);

    // Simultaneous input and output transfer keeps out_valid high
    alloc = vecs(0, 0, 5'b01000, 0, 0);
    cycle();
    check("thru_out_valid", out_valid_a, 1);
    check("thru_sel",       out_sel_a, sels(7, 7, 3, 7, 7));
    held = sels(7, 7, 3, 7, 7);

    // Back-pressure for three cycles with changing input
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      alloc = (k == 0) ? vecs(5'b11111, 5'b11111, 0, 0, 0) :
              (k == 1) ? vecs(0, 5'b00001, 0, 5'b00001, 0) :
                         vecs(0, 0, 0, 0, 5'b00001);
      #1;
      check("stall_in_ready", in_ready_a, 0);
      cycle();
      check("stall_sel",      out_sel_a, held);
      check("stall_conflict", conflict_a, 0);
      check("stall_err",      err_multi_a, 0);
    end
    out_ready = 1'b1; #1;
    check("unstall_in_ready", in_ready_a, 1);
    cycle();
    check("unstall_sel",   out_sel_a, sels(7, 7, 7, 7, 0));
    check("unstall_valid", out_valid_a, 1);
    check("unstall_cnt",   cnt_a, 1);

    // Five conflicting transfers; err_clr combined with a new multi-hot on the second
    for (int k = 0; k < 5; k++) begin
      alloc   = (k == 0) ? vecs(5'b00100, 5'b00100, 0, 0, 5'b11000) :
                (k == 1) ? vecs(5'b00100, 5'b00100, 5'b00110, 0, 0) :
                           vecs(5'b00100, 5'b00100, 0, 0, 0);
      err_clr = (k == 1);
      cycle();
      if (k == 0) check("sat_err_set", err_multi_a, 5'b10000);
      if (k == 1) begin
        check("clr_vs_set_a", err_multi_a, 5'b00100);
        check("clr_vs_set_b", err_multi_b, 5'b00100);
        check("lsb_sel2",     out_sel_b, sels(2, 2, 1, 7, 7));
      end
    end
    err_clr = 1'b0; in_valid = 1'b0; alloc = '0;
    check("sat_cnt_b",  cnt_b, 3);
    check("sat_cnt_a",  cnt_a, 6);
    check("sat_flag",   conflict_b, 1);

    // Reset while a result is held
    in_valid = 1'b1; alloc = vecs(5'b00001, 5'b00001, 0, 0, 0); out_ready = 1'b0;
    cycle();
    check("pre_rst_valid", out_valid_a, 1);
    reset = 1'b1; in_valid = 1'b0;
    cycle();
    reset = 1'b0; out_ready = 1'b1; #1;
    check("mid_rst_valid",    out_valid_a, 0);
    check("mid_rst_sel",      out_sel_a, ALL_IDLE);
    check("mid_rst_conflict", conflict_a, 0);
    check("mid_rst_err",      err_multi_a, 0);
    check("mid_rst_cnt_a",    cnt_a, 0);
    check("mid_rst_cnt_b",    cnt_b, 0);
    check("mid_rst_in_ready", in_ready_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
